ped_countdown_timer: RTL and testbench

PED_COUNTDOWN_TIMER -- requirements
Module: ped_countdown_timer

---
 rtl/ped_countdown_timer_if.sv | 25 ++
 rtl/ped_countdown_timer.sv | 132 +++++++++++++
 tb/tb_ped_countdown_timer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ped_countdown_timer_if.sv
// Control and status bundle for the pedestrian countdown timer.
// The master drives the commands; the slave (the timer) returns the count and flags.
interface ped_countdown_timer_if;
  logic       load;
  logic [6:0] load_val;
  logic       start;
  logic       pause;
  logic       tick;
  logic [6:0] remaining;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       done;
  logic       stall;

  modport master (
    output load, load_val, start, pause,
    input  tick, remaining, tens, ones, running, done, stall
  );

  modport slave (
    input  load, load_val, start, pause,
    output tick, remaining, tens, ones, running, done, stall
  );
endinterface

// File: rtl/ped_countdown_timer.sv
// Pedestrian crossing countdown: counts seconds down on each slow_clk rising edge,
// shows the value as BCD digits and flags a stalled seconds source.
module ped_countdown_timer #(
  parameter int MAX_SEC   = 99,
  parameter int STALL_CYC = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic slow_clk,
  ped_countdown_timer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOADED, RUN, PAUSED, DONE} state_t;

  localparam int              CNT_W     = $clog2(STALL_CYC + 1);
  localparam logic [6:0]      MAX_VAL   = 7'(MAX_SEC);
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_CYC);

  state_t           state;
  logic             s1, s2, s3;
  logic             tick_r;
  logic [6:0]       remaining;
  logic [3:0]       tens, ones;
  logic             done_r;
  logic             stall_r;
  logic [CNT_W-1:0] stall_cnt;
  logic [6:0]       clamped;

  function automatic logic [3:0] tens_of(input logic [6:0] v);
    logic [6:0] q;
    q = v / 7'd10;
    return q[3:0];
  endfunction

  function automatic logic [3:0] ones_of(input logic [6:0] v);
    logic [6:0] r;
    r = v % 7'd10;
    return r[3:0];
  endfunction

  assign clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;

  // slow_clk is asynchronous: two flops resolve metastability, s3 gives edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      s1     <= slow_clk;
      s2     <= s1;
      s3     <= s2;
      tick_r <= s2 & ~s3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= 7'd0;
      tens      <= 4'd0;
      ones      <= 4'd0;
      done_r    <= 1'b0;
      stall_r   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        RUN: begin
          // pause wins over a coincident tick so the displayed value never jumps
          if (bus.pause) begin
            state <= PAUSED;
          end else if (tick_r) begin
            if (remaining == 7'd1) begin
              remaining <= 7'd0;
              tens      <= 4'd0;
              ones      <= 4'd0;
              state     <= DONE;
              done_r    <= 1'b1;
            end else begin
              remaining <= remaining - 7'd1;
              tens      <= tens_of(remaining - 7'd1);
              ones      <= ones_of(remaining - 7'd1);
            end
          end
        end
        default: begin
          if (bus.load) begin
            remaining <= clamped;
            tens      <= tens_of(clamped);
            ones      <= ones_of(clamped);
            state     <= LOADED;
            stall_r   <= 1'b0;
          end else if (bus.start) begin
            if (state == LOADED) begin
              if (remaining != 7'd0) begin
                state <= RUN;
              end else begin
                state  <= DONE;
                done_r <= 1'b1;
              end
            end else if (state == PAUSED && remaining != 7'd0) begin
              state <= RUN;
            end
          end
        end
      endcase

      // Watchdog on the seconds source; saturates so the sticky flag never re-arms
      if (state == RUN && !tick_r) begin
        if (stall_cnt != STALL_LIM) begin
          stall_cnt <= stall_cnt + CNT_W'(1);
          if (stall_cnt + CNT_W'(1) == STALL_LIM) begin
            stall_r <= 1'b1;
          end
        end
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  assign bus.tick      = tick_r;
  assign bus.remaining = remaining;
  assign bus.tens      = tens;
  assign bus.ones      = ones;
  assign bus.running   = (state == RUN);
  assign bus.done      = done_r;
  assign bus.stall     = stall_r;

endmodule

// File: tb/tb_ped_countdown_timer.sv
// Directed bench for ped_countdown_timer; expected values are worked out by hand
// from the slow_clk synchronizer latency and the state machine rules.
module tb_ped_countdown_timer;

  logic clk = 1'b0;
  logic rst;
  logic slow_clk;
  int   n_checks = 0;
  int   n_fail   = 0;

  ped_countdown_timer_if bus ();

  ped_countdown_timer #(.MAX_SEC(99), .STALL_CYC(20)) dut (
    .clk     (clk),
    .rst     (rst),
    .slow_clk(slow_clk),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_remaining"}, 32'(bus.remaining), 0);
    check({tag, "_tens"},      32'(bus.tens), 0);
    check({tag, "_ones"},      32'(bus.ones), 0);
    check({tag, "_tick"},      32'(bus.tick), 0);
    check({tag, "_running"},   32'(bus.running), 0);
    check({tag, "_done"},      32'(bus.done), 0);
    check({tag, "_stall"},     32'(bus.stall), 0);
  endtask

  // One slow_clk period: tick must appear after the 3rd edge only, and the
  // falling half must produce nothing. Optionally pause coincides with the tick.
  task automatic tick_edge(input string tag, input bit with_pause, input int exp_rem,
                           input bit exp_done, input bit exp_running);
    slow_clk = 1'b1;
    cycle(1);
    check({tag, "_tick_e1"}, 32'(bus.tick), 0);
    cycle(1);
    check({tag, "_tick_e2"}, 32'(bus.tick), 0);
    cycle(1);
    check({tag, "_tick_e3"}, 32'(bus.tick), 1);
    if (with_pause) bus.pause = 1'b1;
    cycle(1);
    bus.pause = 1'b0;
    check({tag, "_tick_e4"},  32'(bus.tick), 0);
    check({tag, "_remaining"}, 32'(bus.remaining), 32'(exp_rem));
    check({tag, "_tens"},     32'(bus.tens), 32'(exp_rem / 10));
    check({tag, "_ones"},     32'(bus.ones), 32'(exp_rem % 10));
    check({tag, "_done"},     32'(bus.done), 32'(exp_done));
    check({tag, "_running"},  32'(bus.running), 32'(exp_running));
    slow_clk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1);
      check({tag, "_fall_tick"}, 32'(bus.tick), 0);
      check({tag, "_fall_done"}, 32'(bus.done), 0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    slow_clk     = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 7'd0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    cycle(2);
    check_zero_outputs("reset");
    rst = 1'b0;

    $display("[TB] start ignored in IDLE");
    bus.start = 1'b1;
    cycle(1);
    bus.start = 1'b0;
    check("idle_start_running", 32'(bus.running), 0);
    check("idle_start_done",    32'(bus.done), 0);

    $display("[TB] countdown from 5");
    bus.load = 1'b1; bus.load_val = 7'd5;
    cycle(1);
    bus.load = 1'b0;
    check("load5_remaining", 32'(bus.remaining), 5);
    check("load5_ones",      32'(bus.ones), 5);
    check("load5_running",   32'(bus.running), 0);
    bus.start = 1'b1;
    cycle(1);
    bus.start = 1'b0;
    check("run5_running", 32'(bus.running), 1);
    tick_edge("cd4", 0, 4, 0, 1);
    tick_edge("cd3", 0, 3, 0, 1);
    tick_edge("cd2", 0, 2, 0, 1);
    tick_edge("cd1", 0, 1, 0, 1);
    tick_edge("cd0", 0, 0, 1, 0);
    check("cd_stall", 32'(bus.stall), 0);
    bus.start = 1'b1;
    cycle(1);
    bus.start = 1'b0;
    check("done_start_running", 32'(bus.running), 0);
    check("done_start_done",    32'(bus.done), 0);

    $display("[TB] clamp and zero load");
    bus.load = 1'b1; bus.load_val = 7'd120;
    cycle(1);
    check("clamp_remaining", 32'(bus.remaining), 99);
    check("clamp_tens",      32'(bus.tens), 9);
    check("clamp_ones",      32'(bus.ones), 9);
    bus.load_val = 7'd0;
    cycle(1);
    bus.load = 1'b0;
    check("zero_remaining", 32'(bus.remaining), 0);
    bus.start = 1'b1;
    cycle(1);
    bus.start = 1'b0;
    check("zero_done",    32'(bus.done), 1);
    check("zero_running", 32'(bus.running), 0);
    cycle(1);
    check("zero_done_once", 32'(bus.done), 0);

    $display("[TB] pause against coincident tick");
    bus.load = 1'b1; bus.load_val = 7'd7;
    cycle(1);
    bus.load = 1'b0;
    bus.start = 1'b1;
    cycle(1);
    bus.start = 1'b0;
    check("run7_running", 32'(bus.running), 1);
    tick_edge("pause_tick", 1, 7, 0, 0);
    tick_edge("paused_a", 0, 7, 0, 0);
    tick_edge("paused_b", 0, 7, 0, 0);
    tick_edge("paused_c", 0, 7, 0, 0);
    bus.start = 1'b1;
    cycle(1);
    bus.start = 1'b0;
    check("resume_running", 32'(bus.running), 1);
    tick_edge("resume6", 0, 6, 0, 1);

    $display("[TB] stall watchdog");
    bus.pause = 1'b1;
    cycle(1);
    bus.pause = 1'b0;
    check("pause6_running", 32'(bus.running), 0);
    bus.load = 1'b1; bus.load_val = 7'd10;
    cycle(1);
    bus.load = 1'b0;
    check("load10_remaining", 32'(bus.remaining), 10);
    check("load10_tens",      32'(bus.tens), 1);
    check("load10_ones",      32'(bus.ones), 0);
    bus.start = 1'b1;
    cycle(1);
    bus.start = 1'b0;
    check("stall_c0", 32'(bus.stall), 0);
    for (int i = 1; i < 20; i++) begin
      cycle(1);
      check("stall_early", 32'(bus.stall), 0);
    end
    cycle(1);
    check("stall_c20", 32'(bus.stall), 1);
    cycle(5);
    check("stall_c25", 32'(bus.stall), 1);
    check("stall_still_running", 32'(bus.running), 1);
    tick_edge("stall_tick", 0, 9, 0, 1);
    check("stall_sticky", 32'(bus.stall), 1);
    bus.pause = 1'b1;
    cycle(1);
    bus.pause = 1'b0;
    bus.load = 1'b1; bus.load_val = 7'd4;
    cycle(1);
    bus.load = 1'b0;
    check("stall_cleared",   32'(bus.stall), 0);
    check("load4_remaining", 32'(bus.remaining), 4);

    $display("[TB] reset during RUN");
    bus.start = 1'b1;
    cycle(1);
    bus.start = 1'b0;
    tick_edge("pre_rst", 0, 3, 0, 1);
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    check_zero_outputs("rst_run");
    cycle(1);
    check("rst_no_done", 32'(bus.done), 0);

    $display("[TB] load beats start, load ignored in RUN");
    bus.load = 1'b1; bus.start = 1'b1; bus.load_val = 7'd8;
    cycle(1);
    bus.load = 1'b0; bus.start = 1'b0;
    check("ls_remaining", 32'(bus.remaining), 8);
    check("ls_running",   32'(bus.running), 0);
    cycle(1);
    check("ls_start_dropped", 32'(bus.running), 0);
    bus.start = 1'b1;
    cycle(1);
    bus.start = 1'b0;
    check("ls_run", 32'(bus.running), 1);
    bus.load = 1'b1; bus.load_val = 7'd2;
    cycle(1);
    bus.load = 1'b0;
    check("run_load_ignored", 32'(bus.remaining), 8);
    check("run_load_running", 32'(bus.running), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
